// File: rtl/conv_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_seq_pkg
//  Description : Shared types and helpers for conv_seq_unit: FSM state
//                encoding, accumulator width helper and the output
//                narrowing function (saturating when CONV_SEQ_UNIT_SAT_EN
//                is defined, two's-complement wrap otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_seq_pkg;

    // Pixel sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAC    = 3'd1,
        WAIT   = 3'd2,
        FINISH = 3'd3,
        OUT    = 3'd4
    } state_t;

    // Working width of the narrowing helper; accumulators must be narrower
    localparam int c_NARROW_W = 128;

    // Accumulator width that cannot overflow for 'terms' full-scale products
    function automatic int acc_width(input int data_w, input int terms);
        return 2 * data_w + $clog2(terms) + 1;
    endfunction

    // Narrow a sign-extended value to data_w bits; result is sign-extended
    function automatic logic signed [c_NARROW_W-1:0] narrow(
        input logic signed [c_NARROW_W-1:0] value,
        input int                           data_w
    );
`ifdef CONV_SEQ_UNIT_SAT_EN
        logic signed [c_NARROW_W-1:0] w_hi;
        logic signed [c_NARROW_W-1:0] w_lo;
        w_hi = {c_NARROW_W{1'b1}} >> (c_NARROW_W - data_w + 1);
        w_lo = ~w_hi;
        if (value > w_hi) begin
            return w_hi;
        end
        if (value < w_lo) begin
            return w_lo;
        end
        return value;
`else
        logic [c_NARROW_W-1:0]        w_mask;
        logic signed [c_NARROW_W-1:0] w_wrap;
        w_mask = {c_NARROW_W{1'b1}} >> (c_NARROW_W - data_w);
        w_wrap = value & w_mask;
        if (value[data_w-1]) begin
            w_wrap = w_wrap | ~w_mask;
        end
        return w_wrap;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_seq_wmem.sv
`default_nettype none
// ============================================================================
//  Module      : conv_seq_wmem
//  Description : Weight RAM, one write port and one registered read port
//                (one-cycle read latency). Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_seq_wmem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 450,
    parameter int ADDR_BITS  = 9
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_BITS-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_BITS-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Host write port; out-of-range addresses are ignored
    always_ff @(posedge clk) begin
        if (i_we && (int'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read, only when the sequencer issues a tap
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/conv_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : conv_seq_unit
//  Description : Sequential KxK multi-channel convolution unit. Accepts one
//                window per input channel, MACs one tap per cycle, adds the
//                filter bias, optional ReLU, returns one pixel.
//                Optional macro: CONV_SEQ_UNIT_SAT_EN (saturating narrow).
//                Accumulator width must stay below 128 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_seq_unit
    import conv_seq_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int FRAC_BITS        = 16,
    parameter int KERNAL_SIZE      = 5,
    parameter int IFM_DEPTH        = 6,
    parameter int FILTERS_PER_UNIT = 3,
    parameter int WM_ADDR_BITS     = $clog2(KERNAL_SIZE*KERNAL_SIZE*IFM_DEPTH*FILTERS_PER_UNIT),
    parameter int FSEL_BITS        = (FILTERS_PER_UNIT > 1) ? $clog2(FILTERS_PER_UNIT) : 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [DATA_WIDTH-1:0]                     riscv_data,
    input  logic                                      wm_enable_write,
    input  logic [WM_ADDR_BITS-1:0]                   wm_address,
    input  logic                                      bias_enable_write,
    input  logic [FSEL_BITS-1:0]                      bias_sel,
    input  logic [FSEL_BITS-1:0]                      filter_sel,
    input  logic                                      relu_enable,
    input  logic [KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0] window_in,
    input  logic                                      window_valid,
    output logic                                      window_ready,
    output logic [DATA_WIDTH-1:0]                     unit_data_out,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      busy
);

    localparam int c_TAPS     = KERNAL_SIZE * KERNAL_SIZE;
    localparam int c_DEPTH    = c_TAPS * IFM_DEPTH * FILTERS_PER_UNIT;
    localparam int c_ACC_W    = acc_width(DATA_WIDTH, c_TAPS * IFM_DEPTH);
    localparam int c_TAP_BITS = $clog2(c_TAPS + 1);
    localparam int c_CH_BITS  = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
    localparam int c_PROD_W   = 2 * DATA_WIDTH;

    state_t                          r_state;
    state_t                          w_state_next;
    logic                            r_live;
    logic                            w_can_accept;
    logic                            w_win_accept;
    logic [c_TAPS*DATA_WIDTH-1:0]    r_window;
    logic [FSEL_BITS-1:0]            r_fsel;
    logic                            r_relu;
    logic [c_CH_BITS-1:0]            r_chan;
    logic [c_TAP_BITS-1:0]           r_tap;
    logic [c_TAP_BITS-1:0]           r_tap_d;
    logic                            r_mac_vld;
    logic                            w_last_tap;
    logic                            w_last_chan;
    logic                            w_rd_en;
    logic [WM_ADDR_BITS-1:0]         w_rd_addr;
    logic [DATA_WIDTH-1:0]           w_rd_data;
    logic signed [c_ACC_W-1:0]       r_acc;
    logic signed [DATA_WIDTH-1:0]    r_bias [FILTERS_PER_UNIT];
    logic [DATA_WIDTH-1:0]           r_out;
    logic signed [DATA_WIDTH-1:0]    w_tap_val;
    logic signed [c_PROD_W-1:0]      w_tap_ext;
    logic signed [c_PROD_W-1:0]      w_wgt_ext;
    logic signed [c_PROD_W-1:0]      w_product;
    logic signed [c_ACC_W-1:0]       w_product_ext;
    logic signed [DATA_WIDTH-1:0]    w_bias_val;
    logic signed [c_ACC_W-1:0]       w_bias_ext;
    logic signed [c_ACC_W-1:0]       w_shifted;
    logic signed [c_ACC_W-1:0]       w_sum;
    logic signed [c_ACC_W-1:0]       w_relu;
    logic signed [c_NARROW_W-1:0]    w_narrow;
    logic                            w_unused_narrow_hi;

    assign w_can_accept = r_live && ((r_state == IDLE) || (r_state == WAIT));
    assign w_win_accept = window_valid && w_can_accept;
    assign window_ready = w_can_accept;
    assign w_last_tap   = (r_tap == c_TAP_BITS'(c_TAPS));
    assign w_last_chan  = (r_chan == c_CH_BITS'(IFM_DEPTH - 1));

    // Weight read address: filter, channel and tap interleaved in that order
    assign w_rd_en   = (r_state == MAC) && !w_last_tap;
    assign w_rd_addr = WM_ADDR_BITS'(int'(r_fsel) * IFM_DEPTH * c_TAPS
                                     + int'(r_chan) * c_TAPS + int'(r_tap));

    conv_seq_wmem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (c_DEPTH),
        .ADDR_BITS  (WM_ADDR_BITS)
    ) u_wmem (
        .clk     (clk),
        .i_we    (wm_enable_write && (r_state == IDLE)),
        .i_waddr (wm_address),
        .i_wdata (riscv_data),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // Product of the tap read last cycle with its weight, sign-extended
    assign w_tap_val     = r_window[int'(r_tap_d)*DATA_WIDTH +: DATA_WIDTH];
    assign w_tap_ext     = {{DATA_WIDTH{w_tap_val[DATA_WIDTH-1]}}, w_tap_val};
    assign w_wgt_ext     = {{DATA_WIDTH{w_rd_data[DATA_WIDTH-1]}}, w_rd_data};
    assign w_product     = w_tap_ext * w_wgt_ext;
    assign w_product_ext = {{(c_ACC_W-c_PROD_W){w_product[c_PROD_W-1]}}, w_product};

    // Rescale, bias, ReLU and narrowing for the FINISH cycle
    assign w_bias_val = r_bias[r_fsel];
    assign w_bias_ext = {{(c_ACC_W-DATA_WIDTH){w_bias_val[DATA_WIDTH-1]}}, w_bias_val};
    assign w_shifted  = r_acc >>> FRAC_BITS;
    assign w_sum      = w_shifted + w_bias_ext;
    assign w_relu     = (r_relu && w_sum[c_ACC_W-1]) ? '0 : w_sum;
    assign w_narrow   = narrow({{(c_NARROW_W-c_ACC_W){w_relu[c_ACC_W-1]}}, w_relu}, DATA_WIDTH);
    assign w_unused_narrow_hi = ^w_narrow[c_NARROW_W-1:DATA_WIDTH];

    assign unit_data_out = r_out;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_win_accept) begin
                    w_state_next = MAC;
                end
            end
            MAC: begin
                if (w_last_tap) begin
                    w_state_next = w_last_chan ? FINISH : WAIT;
                end
            end
            WAIT: begin
                if (w_win_accept) begin
                    w_state_next = MAC;
                end
            end
            FINISH: begin
                w_state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Window capture, tap/channel counters, accumulator and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_live    <= 1'b0;
            r_window  <= '0;
            r_fsel    <= '0;
            r_relu    <= 1'b0;
            r_chan    <= '0;
            r_tap     <= '0;
            r_tap_d   <= '0;
            r_mac_vld <= 1'b0;
            r_acc     <= '0;
            r_out     <= '0;
        end else begin
            r_live    <= 1'b1;
            r_mac_vld <= w_rd_en;
            r_tap_d   <= r_tap;
            if (r_mac_vld) begin
                r_acc <= r_acc + w_product_ext;
            end
            case (r_state)
                IDLE: begin
                    if (w_win_accept) begin
                        r_window <= window_in;
                        r_fsel   <= filter_sel;
                        r_relu   <= relu_enable;
                        r_acc    <= '0;
                        r_chan   <= '0;
                        r_tap    <= '0;
                    end
                end
                MAC: begin
                    if (w_last_tap) begin
                        r_tap <= '0;
                        if (!w_last_chan) begin
                            r_chan <= r_chan + 1'b1;
                        end
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                WAIT: begin
                    if (w_win_accept) begin
                        r_window <= window_in;
                    end
                end
                FINISH: begin
                    r_out <= w_narrow[DATA_WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    // Bias registers; host writes only land while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FILTERS_PER_UNIT; i++) begin
                r_bias[i] <= '0;
            end
        end else if (bias_enable_write && (r_state == IDLE)
                     && (int'(bias_sel) < FILTERS_PER_UNIT)) begin
            r_bias[bias_sel] <= riscv_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_seq_unit
//  Description : Self-checking bench for conv_seq_unit (K=3, IFM_DEPTH=2,
//                FRAC_BITS=8). A 32-bit, 3-filter instance covers the main
//                function; a 16-bit instance covers output narrowing
//                (CONV_SEQ_UNIT_SAT_EN selects the expected value).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_seq_unit;

    localparam int DW  = 32;
    localparam int SDW = 16;
    localparam int FB  = 8;
    localparam int K   = 3;
    localparam int ID  = 2;
    localparam int NF  = 3;
    localparam int T   = K * K;
    localparam int AB  = $clog2(T * ID * NF);
    localparam int SAB = $clog2(T * ID);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                reset = 1'b1;
    logic [DW-1:0]       riscv_data = '0;
    logic                wm_enable_write = 1'b0;
    logic [AB-1:0]       wm_address = '0;
    logic                bias_enable_write = 1'b0;
    logic [1:0]          bias_sel = '0;
    logic [1:0]          filter_sel = '0;
    logic                relu_enable = 1'b0;
    logic [T*DW-1:0]     window_in = '0;
    logic                window_valid = 1'b0;
    logic                window_ready;
    logic [DW-1:0]       unit_data_out;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                busy;

    logic [SDW-1:0]      s_riscv_data = '0;
    logic                s_wm_we = 1'b0;
    logic [SAB-1:0]      s_wm_addr = '0;
    logic                s_bias_we = 1'b0;
    logic [T*SDW-1:0]    s_window = '0;
    logic                s_window_valid = 1'b0;
    logic                s_window_ready;
    logic [SDW-1:0]      s_data_out;
    logic                s_out_valid;
    logic                s_out_ready = 1'b0;
    logic                s_busy;

    conv_seq_unit #(
        .DATA_WIDTH(DW), .FRAC_BITS(FB), .KERNAL_SIZE(K),
        .IFM_DEPTH(ID), .FILTERS_PER_UNIT(NF)
    ) dut (
        .clk(clk), .reset(reset), .riscv_data(riscv_data),
        .wm_enable_write(wm_enable_write), .wm_address(wm_address),
        .bias_enable_write(bias_enable_write), .bias_sel(bias_sel),
        .filter_sel(filter_sel), .relu_enable(relu_enable),
        .window_in(window_in), .window_valid(window_valid),
        .window_ready(window_ready), .unit_data_out(unit_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    conv_seq_unit #(
        .DATA_WIDTH(SDW), .FRAC_BITS(FB), .KERNAL_SIZE(K),
        .IFM_DEPTH(ID), .FILTERS_PER_UNIT(1)
    ) dut16 (
        .clk(clk), .reset(reset), .riscv_data(s_riscv_data),
        .wm_enable_write(s_wm_we), .wm_address(s_wm_addr),
        .bias_enable_write(s_bias_we), .bias_sel(1'b0),
        .filter_sel(1'b0), .relu_enable(1'b0),
        .window_in(s_window), .window_valid(s_window_valid),
        .window_ready(s_window_ready), .unit_data_out(s_data_out),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .busy(s_busy)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wmod [NF][ID][T];
    int          bmod [NF];
    logic [31:0] sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_weight(input int f, input int c, input int t, input int val);
        wm_address      = AB'(f * ID * T + c * T + t);
        riscv_data      = val;
        wm_enable_write = 1'b1;
        step();
        wm_enable_write = 1'b0;
        wmod[f][c][t]   = val;
    endtask

    task automatic wr_bias(input int f, input int val);
        bias_sel          = 2'(f);
        riscv_data        = val;
        bias_enable_write = 1'b1;
        step();
        bias_enable_write = 1'b0;
        bmod[f]           = val;
    endtask

    function automatic logic [T*DW-1:0] pack(input int base, input int stp);
        logic [T*DW-1:0] p;
        for (int t = 0; t < T; t++) p[t*DW +: DW] = base + t * stp;
        return p;
    endfunction

    // Reference: full-precision sum of products, floor shift, bias, ReLU, wrap
    function automatic logic [31:0] model(input int f, input bit relu,
                                          input logic [T*DW-1:0] w0,
                                          input logic [T*DW-1:0] w1);
        longint acc;
        longint r;
        logic signed [31:0] x;
        acc = 0;
        for (int c = 0; c < ID; c++) begin
            for (int t = 0; t < T; t++) begin
                x = (c == 0) ? w0[t*DW +: DW] : w1[t*DW +: DW];
                acc += longint'(x) * longint'(wmod[f][c][t]);
            end
        end
        r = (acc >>> FB) + longint'(bmod[f]);
        if (relu && r < 0) r = 0;
        return r[31:0];
    endfunction

    task automatic accept_win(input string tag, output int eno);
        int n;
        n = 0;
        window_valid = 1'b1;
        while (!window_ready && n < 100) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 64'(window_ready), 64'd1);
        @(posedge clk);
        #1;
        eno = cyc;
        window_valid = 1'b0;
    endtask

    // Sends both channel windows; changes filter_sel/relu before channel 1
    task automatic send_pixel(input string tag, input int f0, input int f1, input bit relu,
                              input logic [T*DW-1:0] w0, input logic [T*DW-1:0] w1,
                              input logic [31:0] exp, input bit busy_write);
        int e0, en, n;
        logic [31:0] want;
        sb.push_back(exp);
        filter_sel  = 2'(f0);
        relu_enable = relu;
        window_in   = w0;
        accept_win({tag, "_c0"}, e0);
        filter_sel  = 2'(f1);
        relu_enable = ~relu;
        if (busy_write) begin
            wm_address        = '0;
            bias_sel          = '0;
            riscv_data        = 32'd5000;
            wm_enable_write   = 1'b1;
            bias_enable_write = 1'b1;
            step();
            wm_enable_write   = 1'b0;
            bias_enable_write = 1'b0;
        end
        window_in = w1;
        accept_win({tag, "_c1"}, en);
        check({tag, "_chan_gap"}, 64'(en - e0), 64'(T + 2));
        n = 0;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_latency"}, 64'(cyc - en), 64'(T + 2));
        want = sb.pop_front();
        check({tag, "_data"}, 64'(unit_data_out), 64'(want));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(window_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [T*DW-1:0]  wa, wb;
        logic [T*SDW-1:0] sw;
        logic [31:0]      exp;
        int               n;

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        check("rst_window_ready", 64'(window_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", 64'(unit_data_out), 64'd0);
        reset = 1'b0;
        step();
        check("rst_release_ready", 64'(window_ready), 64'd1);

        // Weights: f0 = 1.0, f1 = -1.0, f2 = distinct per (channel, tap)
        for (int c = 0; c < ID; c++) begin
            for (int t = 0; t < T; t++) begin
                wr_weight(0, c, t, 256);
                wr_weight(1, c, t, -256);
                wr_weight(2, c, t, (c * T + t + 1) * 32 - 300);
            end
        end
        wr_bias(0, 128);
        wr_bias(1, 128);
        wr_bias(2, -64);

        // Basic
        wa = pack(512, 0);
        send_pixel("basic", 0, 0, 1'b0, wa, wa, 32'd9344, 1'b0);
        consume("basic");

        // ReLU on / off with negative weights
        send_pixel("relu_on", 1, 1, 1'b1, wa, wa, 32'd0, 1'b0);
        consume("relu_on");
        send_pixel("relu_off", 1, 1, 1'b0, wa, wa, -32'sd9088, 1'b0);
        consume("relu_off");

        // Filter select latched at channel 0, changed during WAIT
        wa  = pack(-1600, 592);
        wb  = pack(-800, 592);
        exp = model(2, 1'b0, wa, wb);
        send_pixel("fsel", 2, 0, 1'b0, wa, wb, exp, 1'b0);
        consume("fsel");

        // Backpressure with a window waiting upstream
        wa = pack(512, 0);
        send_pixel("bp", 0, 0, 1'b0, wa, wa, 32'd9344, 1'b0);
        window_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", 64'(unit_data_out), 64'd9344);
            check("bp_ready", 64'(window_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_busy", 64'(busy), 64'd0);
        check("bp_release_ready", 64'(window_ready), 64'd1);
        window_valid = 1'b0;
        step();
        check("bp_no_accept", 64'(busy), 64'd0);

        // Narrowing on the 16-bit instance
        for (int i = 0; i < T * ID; i++) begin
            s_wm_addr    = SAB'(i);
            s_riscv_data = 16'd25600;
            s_wm_we      = 1'b1;
            step();
        end
        s_wm_we      = 1'b0;
        s_riscv_data = 16'd128;
        s_bias_we    = 1'b1;
        step();
        s_bias_we = 1'b0;
        for (int t = 0; t < T; t++) sw[t*SDW +: SDW] = 16'd256;
        s_window = sw;
        for (int c = 0; c < ID; c++) begin
            n = 0;
            s_window_valid = 1'b1;
            while (!s_window_ready && n < 100) begin
                step();
                n++;
            end
            check("sat_ready", 64'(s_window_ready), 64'd1);
            step();
            s_window_valid = 1'b0;
        end
        n = 0;
        while (!s_out_valid && n < 60) begin
            step();
            n++;
        end
        check("sat_valid", 64'(s_out_valid), 64'd1);
`ifdef CONV_SEQ_UNIT_SAT_EN
        check("sat_data", 64'(s_data_out), 64'h7FFF);
`else
        check("sat_data", 64'(s_data_out), 64'h0880);
`endif
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;
        check("sat_idle", 64'(s_busy), 64'd0);

        // Reset in the middle of MAC (tap 4), partial pixel discarded
        filter_sel   = '0;
        window_in    = pack(512, 0);
        window_valid = 1'b1;
        step();
        window_valid = 1'b0;
        repeat (4) step();
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(window_ready), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(unit_data_out), 64'd0);
        reset = 1'b0;
        bmod[0] = 0;
        bmod[1] = 0;
        bmod[2] = 0;
        step();
        check("mid_rel_ready", 64'(window_ready), 64'd1);
        repeat (15) step();
        check("mid_no_output", 64'(out_valid), 64'd0);

        // Weights survive reset, biases cleared, busy writes dropped
        wa = pack(512, 0);
        send_pixel("post_rst", 0, 0, 1'b0, wa, wa, 32'd9216, 1'b1);
        consume("post_rst");
        wr_bias(0, 128);
        send_pixel("rerun", 0, 0, 1'b0, wa, wa, 32'd9344, 1'b0);
        consume("rerun");

        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_seq_unit.md
# conv_seq_unit

Sequential, parametrised successor to the fixed 5×5 convolution unit. It stores per-filter kernels and biases written by the RISC-V host. It accepts one K×K input window per input channel over a valid/ready handshake, and multiply-accumulates one tap per cycle across all IFM_DEPTH channels. It then adds the filter bias, optionally applies ReLU, and returns one fixed-point output pixel over a valid/ready handshake. It sits between the IFM line-buffer/window generator and the output feature-map writer, and one instance serves FILTERS_PER_UNIT filters.

## Interface
- DATA_WIDTH, 32: word width, signed fixed-point.
- FRAC_BITS, 16: fractional bits of data, weights and bias.
- KERNAL_SIZE, 5: kernel edge K; taps per channel T = K*K.
- IFM_DEPTH, 6: input channels accumulated per output pixel.
- FILTERS_PER_UNIT, 3: filters stored in this unit.
- WM_ADDR_BITS, $clog2(T*IFM_DEPTH*FILTERS_PER_UNIT): weight address width.
- FSEL_BITS, max(1,$clog2(FILTERS_PER_UNIT)): filter select width.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- riscv_data  in  DATA_WIDTH  host write data for weights and biases.
- wm_enable_write  in  1  write riscv_data to weight memory at wm_address.
- wm_address  in  WM_ADDR_BITS  weight index = f*IFM_DEPTH*T + c*T + t.
- bias_enable_write  in  1  write riscv_data to bias register bias_sel.
- bias_sel  in  FSEL_BITS  bias register index.
- filter_sel  in  FSEL_BITS  filter for the pixel; sampled on channel-0 window accept.
- relu_enable  in  1  sampled on channel-0 window accept.
- window_in  in  T*DATA_WIDTH  tap t at bits [t*DATA_WIDTH +: DATA_WIDTH].
- window_valid / window_ready  in / out  1  window handshake.
- unit_data_out  out  DATA_WIDTH  result pixel.
- out_valid / out_ready  out / in  1  result handshake.
- busy  out  1  high in every state except IDLE.

## Operation
- States are IDLE, MAC, WAIT, FINISH and OUT.
- IDLE: window_ready=1. On accept:
  - latch window, filter_sel and relu_enable;
  - clear accumulator and set channel counter c=0;
  - go to MAC.
- MAC: tap counter t runs 0..T-1 and issues weight reads (1-cycle read latency). The product window[t]*W is added to the accumulator one cycle later. Total T+1 cycles, including the drain.
  - If c<IFM_DEPTH-1: c++ and go to WAIT.
  - Otherwise go to FINISH.
- WAIT: window_ready=1. On accept, latch the window and go to MAC. filter_sel is ignored here.
- FINISH, one cycle:
  - r = (acc >>> FRAC_BITS) + bias[f], computed in ACC_WIDTH;
  - if ReLU was latched and r<0, then r=0;
  - narrow r to DATA_WIDTH (see Configuration);
  - register r into unit_data_out and go to OUT.
- OUT: out_valid=1, with unit_data_out held stable until out_ready. On handshake go to IDLE. There is no overlap with the next window, so there is a one-cycle bubble.
- Arithmetic:
  - product is 2*DATA_WIDTH signed;
  - ACC_WIDTH = 2*DATA_WIDTH + $clog2(T*IFM_DEPTH) + 1, so the accumulator never overflows;
  - the shift truncates toward −inf.
- Host writes to weights and biases are honoured only in IDLE. Writes while busy=1 are dropped with no other effect.
- Weight memory contents survive reset. Bias registers reset to 0.
- filter_sel ≥ FILTERS_PER_UNIT is undefined; the bench must not drive it.

## Timing
- Reset values: window_ready=0, out_valid=0, busy=0, unit_data_out=0.
  - State is IDLE; counters and accumulator are 0.
  - window_ready rises the first cycle after reset falls.
- Reset asserted in any state, including mid-MAC or OUT with out_ready low, returns to IDLE and discards the partial pixel.
- If channel-0 accept is at edge E0 and the last-channel accept is at edge En, out_valid is high from the cycle starting at edge En+T+2.
- With IFM_DEPTH=1, En=E0.
- In WAIT, each channel costs T+1 cycles plus the upstream wait.
- Throughput with no stalls: one pixel per IFM_DEPTH*(T+2)+2 cycles.
- window_ready=0 in MAC, FINISH and OUT. window_valid held across those states is not consumed.
- out_valid with out_ready low stalls indefinitely; the output and state are held.

## Configuration
- CONV_SEQ_UNIT_SAT_EN defined: the narrowing in FINISH saturates to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- CONV_SEQ_UNIT_SAT_EN undefined: the narrowing keeps the low DATA_WIDTH bits (two's-complement wrap).

## Structure
- Package conv_seq_pkg holds:
  - the state enum typedef (IDLE, MAC, WAIT, FINISH, OUT);
  - an ACC_WIDTH helper function;
  - a narrow function, saturating or wrapping under the macro.
- One sub-module, conv_seq_wmem: a single-port-write, registered-read weight RAM of depth T*IFM_DEPTH*FILTERS_PER_UNIT.

## Test plan
All scenarios use K=3, IFM_DEPTH=2, FRAC_BITS=8, unless stated otherwise.
- Basic: DATA_WIDTH=32; all weights 256 (1.0), all window taps 512 (2.0), bias 128 (0.5), ReLU off -> out_valid at En+11, unit_data_out=9344 (36.5).
- ReLU: same as Basic but weights −256 -> ReLU on gives 0; ReLU off gives −9088.
- Saturation: DATA_WIDTH=16; weights 25600 (100.0), taps 256, bias 128 -> 0x7FFF with CONV_SEQ_UNIT_SAT_EN; 0x0880 without it.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and data stable, window_ready=0 throughout. Release -> IDLE the next cycle.
- Reset mid-MAC (t=4), then a host write while busy: the dropped write leaves weights unchanged. After reset, window_ready=1 and a rerun of Basic yields 9344.
- Filter select: FILTERS_PER_UNIT=3 with distinct weights per filter; filter_sel=2 at channel 0, changed to 0 during WAIT -> result uses filter 2 only.
